// File: rtl/fpro_bus_arbiter.sv
// fpro_bus_arbiter: two-master arbiter/sequencer for the FPro bus.
// Grants one master per transaction, issues a one-cycle fp_wr/fp_rd strobe,
// waits out the slave read latency and returns data plus a one-cycle ack.
// Build option: define FPRO_ARB_FIXED_PRIORITY_EN for fixed priority
// (master 0 always wins a tie); otherwise ties alternate round-robin.
module fpro_bus_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic        m0_video,
    input  logic [20:0] m0_addr,
    input  logic [31:0] m0_wr_data,
    output logic [31:0] m0_rd_data,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic        m1_video,
    input  logic [20:0] m1_addr,
    input  logic [31:0] m1_wr_data,
    output logic [31:0] m1_rd_data,
    output logic        m1_ack,
    output logic        fp_video_cs,
    output logic        fp_mmio_cs,
    output logic        fp_wr,
    output logic        fp_rd,
    output logic [20:0] fp_addr,
    output logic [31:0] fp_wr_data,
    input  logic [31:0] fp_rd_data
);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("fpro_bus_arbiter: RD_LAT must be in 1..4");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, ACK} state_t;

    localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

    state_t      state, state_nxt;
    logic        cmd_wr, cmd_video, owner;
    logic [20:0] cmd_addr;
    logic [31:0] cmd_data;
    logic [1:0]  lat_cnt;
    logic        any_req, grant;

    assign any_req = m0_req | m1_req;

`ifdef FPRO_ARB_FIXED_PRIORITY_EN
    // master 0 wins whenever it requests; master 1 may starve
    assign grant = ~m0_req;
`else
    logic last_grant;

    // tie goes to the master that did not win last time
    always_comb begin
        grant = m1_req;
        if (m0_req && m1_req)
            grant = ~last_grant;
    end

    // remember the winner as the transaction enters ISSUE
    always_ff @(posedge clk) begin
        if (!reset_n)
            last_grant <= 1'b1;
        else if (state == IDLE && any_req)
            last_grant <= grant;
    end
`endif

    // state register
    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = cmd_wr ? ACK : RDWAIT;
            RDWAIT:  if (lat_cnt == 2'd0) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // latch the winner's command; held through ACK so the bus stays stable
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cmd_wr    <= 1'b0;
            cmd_video <= 1'b0;
            owner     <= 1'b0;
            cmd_addr  <= '0;
            cmd_data  <= '0;
        end else if (state == IDLE && any_req) begin
            owner     <= grant;
            cmd_wr    <= grant ? m1_wr      : m0_wr;
            cmd_video <= grant ? m1_video   : m0_video;
            cmd_addr  <= grant ? m1_addr    : m0_addr;
            cmd_data  <= grant ? m1_wr_data : m0_wr_data;
        end
    end

    // read latency down-counter, loaded during ISSUE
    always_ff @(posedge clk) begin
        if (!reset_n)
            lat_cnt <= 2'd0;
        else if (state == ISSUE)
            lat_cnt <= LAT_LOAD;
        else if (state == RDWAIT)
            lat_cnt <= lat_cnt - 2'd1;
    end

    // capture slave data on the last wait cycle into the owner's register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            m0_rd_data <= '0;
            m1_rd_data <= '0;
        end else if (state == RDWAIT && lat_cnt == 2'd0) begin
            if (owner)
                m1_rd_data <= fp_rd_data;
            else
                m0_rd_data <= fp_rd_data;
        end
    end

    assign fp_video_cs = (state == ISSUE) &&  cmd_video;
    assign fp_mmio_cs  = (state == ISSUE) && !cmd_video;
    assign fp_wr       = (state == ISSUE) &&  cmd_wr;
    assign fp_rd       = (state == ISSUE) && !cmd_wr;
    assign fp_addr     = cmd_addr;
    assign fp_wr_data  = cmd_data;
    assign m0_ack      = (state == ACK) && !owner;
    assign m1_ack      = (state == ACK) &&  owner;

endmodule
